// File: rtl/bcd_scan_sequencer_pkg.sv
// Shared types and helpers for the BCD row-strobe scan sequencer.
// Defines the FSM states, the idle code and the row-to-code mapping.
package kangaroo_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } scan_state_t;

    localparam logic [3:0] BCD_NONE = 4'hF;

    // Rows outside the scanned range map to the idle code so the decoder deselects everything.
    function automatic logic [3:0] row_to_bcd(input logic [3:0] row, input int rows);
        return (int'(row) < rows) ? row : BCD_NONE;
    endfunction

endpackage

// File: rtl/bcd_scan_sequencer_dwell_timer.sv
// Settle-time counter: held at zero by start_i, counts while run_i is high,
// and raises done_o on the last settle clock.
module scan_dwell_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] settle_cyc_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = run_i && (cnt_q == settle_cyc_i - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i && !done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_scan_sequencer.sv
// Drives BCD row codes onto an LS42-style decoder, samples the active-low return
// lines after a settle time and hands complete frames to the consumer via valid/ack.
module bcd_scan_sequencer
    import kangaroo_scan_pkg::*;
#(
    parameter int ROWS       = 10,
    parameter int COLS       = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [3:0]           bcd,
    input  logic [COLS-1:0]      row_sense,
    output logic [ROWS*COLS-1:0] frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ack,
    output logic                 overrun,
    output logic                 busy
);

    localparam int         FW       = ROWS * COLS;
    localparam int         CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    scan_state_t   state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [FW-1:0] shadow_q, shadow_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic [FW-1:0] sample_vec;
    logic          dwell_done;

    scan_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk          (clk),
        .reset        (reset),
        .start_i      (state_q != SETTLE),
        .run_i        (state_q == SETTLE),
        .settle_cyc_i (CNT_W'(SETTLE_CYC)),
        .done_o       (dwell_done)
    );

    // Shadow image with the current row replaced by the (inverted) return lines.
    always_comb begin
        sample_vec = shadow_q;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == 4'(r)) begin
                sample_vec[r*COLS +: COLS] = ~row_sense;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        bcd_d     = bcd_q;
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && frame_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bcd_d = BCD_NONE;
                if (enable) begin
                    state_d = SETTLE;
                    row_d   = '0;
                    bcd_d   = row_to_bcd(4'd0, ROWS);
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d  = IDLE;
                    bcd_d    = BCD_NONE;
                    shadow_d = '0;
                end else if (dwell_done) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!enable) begin
                    state_d  = IDLE;
                    bcd_d    = BCD_NONE;
                    shadow_d = '0;
                end else begin
                    state_d  = SETTLE;
                    shadow_d = sample_vec;
                    if (row_q == LAST_ROW) begin
                        row_d = '0;
                        bcd_d = row_to_bcd(4'd0, ROWS);
                        // A pending frame is only replaced if the consumer takes it on this clock.
                        if (!valid_q || frame_ack) begin
                            frame_d = sample_vec;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        row_d = row_q + 4'd1;
                        bcd_d = row_to_bcd(row_q + 4'd1, ROWS);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bcd_d   = BCD_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            bcd_q     <= BCD_NONE;
            shadow_q  <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            bcd_q     <= bcd_d;
            shadow_q  <= shadow_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bcd         = bcd_q;
    assign frame_data  = frame_q;
    assign frame_valid = valid_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q == SETTLE) || (state_q == SAMPLE);

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// Directed bench: LS42 decoder model plus a key matrix feeding two sequencer
// instances (default sizing and a 3-row, 1-clock-settle variant).
module tb_bcd_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, frame_ack;
    logic [3:0]  bcd;
    logic [7:0]  row_sense;
    logic [79:0] frame_data;
    logic        frame_valid, overrun, busy;

    logic        enable3, ack3;
    logic [3:0]  bcd3;
    logic [7:0]  row_sense3;
    logic [23:0] frame_data3;
    logic        frame_valid3, overrun3, busy3;

    logic [9:0][7:0] keys;
    logic [2:0][7:0] keys3;
    logic [9:0]      dec, dec3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [79:0] f1, f3, f4;
    logic [3:0]  exp3 [6];

    bcd_scan_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bcd         (bcd),
        .row_sense   (row_sense),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .overrun     (overrun),
        .busy        (busy)
    );

    bcd_scan_sequencer #(
        .ROWS       (3),
        .COLS       (8),
        .SETTLE_CYC (1)
    ) dut3 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable3),
        .bcd         (bcd3),
        .row_sense   (row_sense3),
        .frame_data  (frame_data3),
        .frame_valid (frame_valid3),
        .frame_ack   (ack3),
        .overrun     (overrun3),
        .busy        (busy3)
    );

    // LS42: one active-low output per valid BCD code, all high for 10..15.
    function automatic logic [9:0] ls42(input logic [3:0] code);
        logic [9:0] o;
        o = '1;
        if (code < 4'd10) o[code] = 1'b0;
        return o;
    endfunction

    always_comb begin
        dec       = ls42(bcd);
        row_sense = '1;
        for (int r = 0; r < 10; r++) begin
            if (!dec[r]) row_sense = row_sense & ~keys[r];
        end
    end

    always_comb begin
        dec3       = ls42(bcd3);
        row_sense3 = '1;
        for (int r = 0; r < 3; r++) begin
            if (!dec3[r]) row_sense3 = row_sense3 & ~keys3[r];
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        frame_ack = 1'b0;
        enable3   = 1'b0;
        ack3      = 1'b0;
        keys      = '0;
        keys3     = '0;
        keys[3][2] = 1'b1;
        keys[9][7] = 1'b1;
        f1 = (80'd1 << 26) | (80'd1 << 79);
        f3 = f1 | (80'd1 << 44);
        f4 = 80'd1 << 57;
        exp3[0] = 4'd0; exp3[1] = 4'd0; exp3[2] = 4'd1;
        exp3[3] = 4'd1; exp3[4] = 4'd2; exp3[5] = 4'd2;

        // Reset held three clocks with enable high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_bcd",     80'(bcd),         80'(4'hF));
            chk("rst_valid",   80'(frame_valid), 80'(0));
            chk("rst_data",    frame_data,       80'(0));
            chk("rst_busy",    80'(busy),        80'(0));
            chk("rst_overrun", 80'(overrun),     80'(0));
        end
        reset = 1'b0;

        // Full scan: edge 0 is the first edge after release
        tick();
        chk("start_bcd",  80'(bcd),  80'(0));
        chk("start_busy", 80'(busy), 80'(1));
        for (int k = 1; k < 50; k++) begin
            tick();
            chk("scan_bcd", 80'(bcd), 80'(k / 5));
            if (k == 49) chk("pre_commit_valid", 80'(frame_valid), 80'(0));
        end
        tick();
        chk("f1_valid",   80'(frame_valid), 80'(1));
        chk("f1_data",    frame_data,       f1);
        chk("f1_overrun", 80'(overrun),     80'(0));
        chk("f1_bcd",     80'(bcd),         80'(0));

        // Never ack: frame 2 (with an extra key) is dropped at edge 100
        keys[0][0] = 1'b1;
        ticks(49);
        chk("e99_overrun", 80'(overrun),     80'(0));
        chk("e99_valid",   80'(frame_valid), 80'(1));
        tick();
        chk("drop_overrun", 80'(overrun),     80'(1));
        chk("drop_data",    frame_data,       f1);
        chk("drop_valid",   80'(frame_valid), 80'(1));
        tick();
        chk("overrun_pulse", 80'(overrun), 80'(0));

        // Ack on the exact commit clock of the next frame
        keys[0][0] = 1'b0;
        keys[5][4] = 1'b1;
        ticks(48);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ackc_valid",   80'(frame_valid), 80'(1));
        chk("ackc_data",    frame_data,       f3);
        chk("ackc_overrun", 80'(overrun),     80'(0));

        // Drop enable mid-SETTLE of row 5 (edge 177)
        ticks(27);
        chk("mid_bcd",  80'(bcd),  80'(5));
        chk("mid_busy", 80'(busy), 80'(1));
        enable = 1'b0;
        tick();
        chk("stop_bcd",   80'(bcd),         80'(4'hF));
        chk("stop_busy",  80'(busy),        80'(0));
        chk("stop_valid", 80'(frame_valid), 80'(1));
        chk("stop_data",  frame_data,       f3);
        ticks(3);
        chk("idle_bcd",  80'(bcd),        80'(4'hF));
        chk("idle_data", frame_data,      f3);

        // Handshake: ack clears valid; ack with valid low is ignored
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_clr_valid", 80'(frame_valid), 80'(0));
        chk("ack_clr_data",  frame_data,       f3);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_idle_valid", 80'(frame_valid), 80'(0));

        // Re-enable restarts from row 0 with a full 50-clock scan
        keys       = '0;
        keys[7][1] = 1'b1;
        enable     = 1'b1;
        tick();
        chk("re_bcd",  80'(bcd),  80'(0));
        chk("re_busy", 80'(busy), 80'(1));
        ticks(49);
        chk("re_pre_valid", 80'(frame_valid), 80'(0));
        tick();
        chk("re_valid",   80'(frame_valid), 80'(1));
        chk("re_data",    frame_data,       f4);
        chk("re_overrun", 80'(overrun),     80'(0));

        // Three rows, one-clock settle
        chk("r3_idle_bcd", 80'(bcd3), 80'(4'hF));
        keys3[1][5] = 1'b1;
        keys3[2][0] = 1'b1;
        enable3     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("r3_bcd",   80'(bcd3),         80'(exp3[k]));
            chk("r3_valid", 80'(frame_valid3), 80'(0));
        end
        tick();
        chk("r3_f_valid", 80'(frame_valid3), 80'(1));
        chk("r3_f_data",  80'(frame_data3),  80'(24'h012000));
        chk("r3_f_bcd",   80'(bcd3),         80'(0));
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("r3_code_range", 80'(bcd3 < 4'd3), 80'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
